// File: rtl/rx_rss_sched_if.sv
// Hash-result input and queue-selection output bundle of the RSS scheduler.
interface rx_rss_sched_if #(
  parameter int QUEUE_WIDTH = 8
);
  logic [31:0]            s_hash;
  logic [3:0]             s_hash_type;
  logic                   s_hash_valid;
  logic [QUEUE_WIDTH-1:0] m_queue;
  logic [31:0]            m_hash;
  logic [3:0]             m_hash_type;
  logic                   m_valid;
  logic                   m_ready;

  modport master (
    output s_hash, s_hash_type, s_hash_valid, m_ready,
    input  m_queue, m_hash, m_hash_type, m_valid
  );

  modport slave (
    input  s_hash, s_hash_type, s_hash_valid, m_ready,
    output m_queue, m_hash, m_hash_type, m_valid
  );
endinterface

// File: rtl/rx_rss_sched.sv
// RSS scheduler: owns the Toeplitz key (swapped only between frames), maps hashes
// to queues through an indirection table, and buffers results in a FWFT FIFO.
module rx_rss_sched #(
  parameter int TABLE_ADDR_WIDTH = 7,
  parameter int QUEUE_WIDTH      = 8,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  rx_rss_sched_if.slave               bus,
  input  logic                        mon_tvalid,
  input  logic                        mon_tlast,
  output logic [319:0]                hash_key,
  input  logic                        rss_enable,
  input  logic [QUEUE_WIDTH-1:0]      default_queue,
  input  logic                        cfg_tbl_valid,
  output logic                        cfg_tbl_ready,
  input  logic [TABLE_ADDR_WIDTH-1:0] cfg_tbl_addr,
  input  logic [QUEUE_WIDTH-1:0]      cfg_tbl_data,
  input  logic                        cfg_key_wr,
  input  logic [5:0]                  cfg_key_addr,
  input  logic [7:0]                  cfg_key_data,
  input  logic                        cfg_key_commit,
  output logic                        cfg_key_pending,
  output logic [15:0]                 drop_count
);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = QUEUE_WIDTH + 36;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic       in_frame;
  logic [7:0] shadow [40];
  logic       key_copy;

  // A pending key is applied only on an idle, out-of-frame cycle so the hash
  // block never sees the key change under a frame.
  assign key_copy = cfg_key_pending && !in_frame && !mon_tvalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_frame        <= 1'b0;
      cfg_key_pending <= 1'b0;
      hash_key        <= '0;
      for (int i = 0; i < 40; i++) shadow[i] <= '0;
    end else begin
      if (mon_tvalid) in_frame <= !mon_tlast;
      if (key_copy)
        cfg_key_pending <= 1'b0;
      else if (cfg_key_commit)
        cfg_key_pending <= 1'b1;
      if (cfg_key_wr && cfg_key_addr < 6'd40) shadow[cfg_key_addr] <= cfg_key_data;
      if (key_copy)
        for (int i = 0; i < 40; i++) hash_key[319-8*i -: 8] <= shadow[i];
    end
  end

  assign cfg_tbl_ready = !bus.s_hash_valid;

  logic [QUEUE_WIDTH-1:0] tbl [2**TABLE_ADDR_WIDTH];
  logic [QUEUE_WIDTH-1:0] tbl_q_p1;
  logic [QUEUE_WIDTH-1:0] dq_p1;
  logic [31:0]            hash_p1;
  logic [3:0]             type_p1;
  logic                   sel_default_p1;
  logic                   vld_p1;

  // Stage 1: table read (lookup wins the single port) and operand capture
  always_ff @(posedge clk) begin
    if (bus.s_hash_valid) begin
      tbl_q_p1       <= tbl[bus.s_hash[TABLE_ADDR_WIDTH-1:0]];
      hash_p1        <= bus.s_hash;
      type_p1        <= bus.s_hash_type;
      sel_default_p1 <= !rss_enable || !bus.s_hash_type[0];
      dq_p1          <= default_queue;
    end else if (cfg_tbl_valid) begin
      tbl[cfg_tbl_addr] <= cfg_tbl_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= bus.s_hash_valid;
  end

  // Stage 2: queue select and FIFO push
  logic [ENTRY_W-1:0] entry_p1;
  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [PTR_W:0]     count;
  logic               full, pop, push_ok, drop;

  assign entry_p1 = {sel_default_p1 ? dq_p1 : tbl_q_p1, hash_p1, type_p1};
  assign full     = (count == FULL_CNT);
  assign pop      = bus.m_valid && bus.m_ready;
  assign push_ok  = vld_p1 && (!full || pop);
  assign drop     = vld_p1 && full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= entry_p1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      drop_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PTR_W{1'b0}}, push_ok} - {{PTR_W{1'b0}}, pop};
      if (drop) drop_count <= sat_inc16(drop_count);
    end
  end

  // Outputs read zero while empty so reset leaves m_* at 0 without clearing RAM.
  assign bus.m_valid = (count != '0);
  assign {bus.m_queue, bus.m_hash, bus.m_hash_type} = bus.m_valid ? fifo_mem[rd_ptr] : '0;
endmodule

// File: tb/tb_rx_rss_sched.sv
// Randomized scoreboard bench for rx_rss_sched with directed key/table/overflow/reset cases.
module tb_rx_rss_sched;
  localparam int TAW = 7;
  localparam int QW  = 8;
  localparam int FD  = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           mon_tvalid, mon_tlast;
  logic [319:0]   hash_key;
  logic           rss_enable;
  logic [QW-1:0]  default_queue;
  logic           cfg_tbl_valid, cfg_tbl_ready;
  logic [TAW-1:0] cfg_tbl_addr;
  logic [QW-1:0]  cfg_tbl_data;
  logic           cfg_key_wr;
  logic [5:0]     cfg_key_addr;
  logic [7:0]     cfg_key_data;
  logic           cfg_key_commit, cfg_key_pending;
  logic [15:0]    drop_count;

  always #5 clk = ~clk;

  rx_rss_sched_if #(.QUEUE_WIDTH(QW)) bus ();

  rx_rss_sched #(.TABLE_ADDR_WIDTH(TAW), .QUEUE_WIDTH(QW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .mon_tvalid(mon_tvalid), .mon_tlast(mon_tlast), .hash_key(hash_key),
    .rss_enable(rss_enable), .default_queue(default_queue),
    .cfg_tbl_valid(cfg_tbl_valid), .cfg_tbl_ready(cfg_tbl_ready),
    .cfg_tbl_addr(cfg_tbl_addr), .cfg_tbl_data(cfg_tbl_data),
    .cfg_key_wr(cfg_key_wr), .cfg_key_addr(cfg_key_addr), .cfg_key_data(cfg_key_data),
    .cfg_key_commit(cfg_key_commit), .cfg_key_pending(cfg_key_pending),
    .drop_count(drop_count)
  );

  typedef struct packed {
    logic [QW-1:0] q;
    logic [31:0]   h;
    logic [3:0]    t;
  } exp_t;

  exp_t          sb[$];
  logic [QW-1:0] model_tbl [2**TAW];
  int            errors = 0;
  int            checks = 0;

  logic [7:0] ms_key [40] = '{
    8'h6d, 8'h5a, 8'h56, 8'hda, 8'h25, 8'h5b, 8'h0e, 8'hc2,
    8'h41, 8'h67, 8'h25, 8'h3d, 8'h43, 8'ha3, 8'h8f, 8'hb0,
    8'hd0, 8'hca, 8'h2b, 8'hcb, 8'hae, 8'h7b, 8'h30, 8'hb4,
    8'h77, 8'hcb, 8'h2d, 8'ha3, 8'h80, 8'h30, 8'hf2, 8'h0c,
    8'h6a, 8'h42, 8'hb7, 8'h3b, 8'hbe, 8'hac, 8'h01, 8'hfa};
  logic [319:0] exp_key;

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t predict(input logic [31:0] h, input logic [3:0] t,
                                   input logic rss, input logic [QW-1:0] dq);
    exp_t e;
    e.q = (!rss || !t[0]) ? dq : model_tbl[h[TAW-1:0]];
    e.h = h;
    e.t = t;
    return e;
  endfunction

  // A table write only lands when no lookup occupies the port that cycle.
  task automatic tick();
    if (cfg_tbl_valid && !bus.s_hash_valid) model_tbl[cfg_tbl_addr] = cfg_tbl_data;
    @(posedge clk);
    #1;
    bus.s_hash_valid = 1'b0;
    cfg_tbl_valid    = 1'b0;
    cfg_key_wr       = 1'b0;
    cfg_key_commit   = 1'b0;
    mon_tvalid       = 1'b0;
    mon_tlast        = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] h, input logic [3:0] t);
    bus.s_hash       = h;
    bus.s_hash_type  = t;
    bus.s_hash_valid = 1'b1;
    sb.push_back(predict(h, t, rss_enable, default_queue));
  endtask

  task automatic tbl_write(input logic [TAW-1:0] a, input logic [QW-1:0] d);
    cfg_tbl_valid = 1'b1;
    cfg_tbl_addr  = a;
    cfg_tbl_data  = d;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check(name, sb.size(), 0);
  endtask

  logic        hold_vld = 1'b0;
  logic [44:0] hold_val;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold_vld = 1'b0;
    end else begin
      if (hold_vld)
        check("hold_stable", {bus.m_valid, bus.m_queue, bus.m_hash, bus.m_hash_type}, hold_val);
      hold_vld = bus.m_valid && !bus.m_ready;
      hold_val = {bus.m_valid, bus.m_queue, bus.m_hash, bus.m_hash_type};
      if (bus.m_valid && bus.m_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          check("m_queue", bus.m_queue, e.q);
          check("m_hash", bus.m_hash, e.h);
          check("m_hash_type", bus.m_hash_type, e.t);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.s_hash = '0; bus.s_hash_type = '0; bus.s_hash_valid = 1'b0; bus.m_ready = 1'b1;
    mon_tvalid = 0; mon_tlast = 0; rss_enable = 1; default_queue = '0;
    cfg_tbl_valid = 0; cfg_tbl_addr = '0; cfg_tbl_data = '0;
    cfg_key_wr = 0; cfg_key_addr = '0; cfg_key_data = '0; cfg_key_commit = 0;
    for (int i = 0; i < 40; i++) exp_key[319-8*i -: 8] = ms_key[i];

    repeat (2) @(posedge clk);
    #1;
    check("rst_hash_key", hash_key, 0);
    check("rst_pending", cfg_key_pending, 0);
    check("rst_tbl_ready", cfg_tbl_ready, 1);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_queue", bus.m_queue, 0);
    check("rst_m_hash", bus.m_hash, 0);
    check("rst_m_hash_type", bus.m_hash_type, 0);
    check("rst_drop_count", drop_count, 0);
    rst = 1'b0;
    tick();

    for (int a = 0; a < 2**TAW; a++) begin
      tbl_write(a[TAW-1:0], QW'($urandom));
      tick();
    end

    // Table sequencing and latency
    tbl_write(7'd5, 8'h03);
    tick();
    lookup(32'h12345685, 4'h5);
    tick();
    check("lat_edge1_m_valid", bus.m_valid, 0);
    tick();
    check("lat_edge2_m_valid", bus.m_valid, 1);
    check("seq_m_queue", bus.m_queue, 8'h03);
    check("seq_m_hash", bus.m_hash, 32'h12345685);
    wait_drain("drain_seq");

    // Default selection
    default_queue = 8'h07;
    lookup(32'h12345685, 4'h0);
    tick();
    rss_enable = 1'b0;
    lookup(32'h12345685, 4'h5);
    tick();
    rss_enable = 1'b1;
    default_queue = 8'h00;
    wait_drain("drain_default");

    // Write/lookup collision
    tbl_write(7'h22, 8'h11);
    tick();
    lookup(32'hABCD00A2, 4'h5);
    tbl_write(7'h22, 8'h44);
    #1;
    check("collide_tbl_ready", cfg_tbl_ready, 0);
    tick();
    tbl_write(7'h22, 8'h44);
    #1;
    check("retry_tbl_ready", cfg_tbl_ready, 1);
    tick();
    lookup(32'h000000A2, 4'h5);
    tick();
    wait_drain("drain_collide");

    // Key commit deferral
    for (int i = 0; i < 40; i++) begin
      cfg_key_wr = 1'b1; cfg_key_addr = i[5:0]; cfg_key_data = ms_key[i];
      tick();
    end
    cfg_key_wr = 1'b1; cfg_key_addr = 6'd45; cfg_key_data = 8'hEE;
    tick();
    mon_tvalid = 1'b1; mon_tlast = 1'b0;
    tick();
    cfg_key_commit = 1'b1;
    tick();
    check("midframe_pending", cfg_key_pending, 1);
    check("midframe_key", hash_key, 0);
    repeat (2) tick();
    mon_tvalid = 1'b1; mon_tlast = 1'b0;
    tick();
    check("midbeat_key", hash_key, 0);
    mon_tvalid = 1'b1; mon_tlast = 1'b1;
    tick();
    check("tlast_pending", cfg_key_pending, 1);
    check("tlast_key", hash_key, 0);
    cfg_key_wr = 1'b1; cfg_key_addr = 6'd0; cfg_key_data = 8'hFF;
    tick();
    check("copy_pending", cfg_key_pending, 0);
    check("copy_key", hash_key, exp_key);
    check("copy_key_byte0", hash_key[319:312], 8'h6D);

    // Second commit, blocked one cycle by a single-beat frame
    exp_key[319:312] = 8'hFF;
    cfg_key_commit = 1'b1;
    tick();
    check("commit2_pending", cfg_key_pending, 1);
    mon_tvalid = 1'b1; mon_tlast = 1'b1;
    tick();
    check("beat_block_pending", cfg_key_pending, 1);
    check("beat_block_key_byte0", hash_key[319:312], 8'h6D);
    tick();
    check("commit2_done_pending", cfg_key_pending, 0);
    check("commit2_key", hash_key, exp_key);

    // Overflow: six results into a four-entry FIFO with no drain
    bus.m_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      lookup($urandom, 4'($urandom_range(0, 15)));
      tick();
    end
    void'(sb.pop_back());
    void'(sb.pop_back());
    repeat (3) tick();
    check("ovf_drop_count", drop_count, 2);
    check("ovf_m_valid", bus.m_valid, 1);
    bus.m_ready = 1'b1;
    wait_drain("drain_ovf");
    tick();
    check("ovf_empty", bus.m_valid, 0);

    // Asynchronous reset with two queued and one in flight
    bus.m_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      lookup($urandom, 4'h5);
      tick();
    end
    check("pre_rst_m_valid", bus.m_valid, 1);
    #1;
    rst = 1'b1;
    #1;
    check("arst_m_valid", bus.m_valid, 0);
    check("arst_drop_count", drop_count, 0);
    check("arst_m_queue", bus.m_queue, 0);
    check("arst_hash_key", hash_key, 0);
    sb.delete();
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("inflight_lost", bus.m_valid, 0);
    bus.m_ready = 1'b1;
    lookup(32'h00000005, 4'h5);
    tick();
    tick();
    check("tbl_retained", bus.m_queue, 8'h03);
    wait_drain("drain_rst");

    // Randomized traffic with table updates and backpressure
    for (int n = 0; n < 800; n++) begin
      bus.m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1 && sb.size() < FD) begin
        rss_enable    = ($urandom_range(0, 7) != 0);
        default_queue = QW'($urandom);
        lookup($urandom, 4'($urandom_range(0, 15)));
      end
      if ($urandom_range(0, 3) == 0) tbl_write(TAW'($urandom), QW'($urandom));
      tick();
    end
    bus.m_ready = 1'b1;
    wait_drain("drain_random");
    check("random_no_drops", drop_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rx_rss_sched.md
# rx_rss_sched

Receive-side scaling scheduler that sits directly behind the receive hash block. It owns the 40-byte Toeplitz key driven into the hash block and swaps in new keys only between frames. It maps each hash result to a receive queue through a programmable indirection table. Results are buffered in a small FIFO toward the queue/DMA selection logic.

## Interface
- TABLE_ADDR_WIDTH, 7: log2 of indirection table entries (128).
- QUEUE_WIDTH, 8: queue index width.
- FIFO_DEPTH, 4: output FIFO entries, power of two, ≥2.

Ports:
- clk  in  1  Clock.
- rst  in  1  Reset. Asynchronous, active-high.
- mon_tvalid  in  1  Receive stream valid, same stream the hash block parses.
- mon_tlast  in  1  Receive stream last.
- s_hash  in  32  Hash result.
- s_hash_type  in  4  Hash type. Bit0 = IPv4, bit2 = TCP, bit3 = UDP. 0 = unhashed.
- s_hash_valid  in  1  Hash result strobe. Single cycle, no backpressure.
- hash_key  out  320  Active key. Byte 0 is at [319:312], byte i at [319-8i -: 8].
- rss_enable  in  1  0 forces every result to default_queue.
- default_queue  in  QUEUE_WIDTH  Queue used for unhashed frames or when RSS is disabled.
- cfg_tbl_valid  in  1  Table write request.
- cfg_tbl_ready  out  1  Table write accepted.
- cfg_tbl_addr  in  TABLE_ADDR_WIDTH  Table index.
- cfg_tbl_data  in  QUEUE_WIDTH  Queue value.
- cfg_key_wr  in  1  Shadow key byte write strobe.
- cfg_key_addr  in  6  Byte index, 0–39. Values 40–63 are ignored.
- cfg_key_data  in  8  Key byte.
- cfg_key_commit  in  1  Request shadow→active copy.
- cfg_key_pending  out  1  A commit is requested but not yet applied.
- m_queue  out  QUEUE_WIDTH  Selected queue.
- m_hash  out  32  Hash passed through.
- m_hash_type  out  4  Type passed through.
- m_valid  out  1  Output valid.
- m_ready  in  1  Output ready.
- drop_count  out  16  Results dropped on FIFO overflow. Saturates at 0xFFFF.

## Operation
- Frame tracking: in_frame is set on a beat with mon_tvalid=1 and mon_tlast=0. It is cleared on a beat with mon_tvalid=1 and mon_tlast=1.
- Key path:
  - cfg_key_wr writes one shadow byte per cycle.
  - cfg_key_commit sets the pending flag.
  - The copy shadow→hash_key happens on the first edge where pending=1 and in_frame=0 and the current cycle carries no mon_tvalid beat. The same edge clears pending.
  - A commit issued while pending=1 has no additional effect.
  - A shadow write in the same cycle as the copy is not included in that copy.
- Indirection table: single-port RAM of 2^TABLE_ADDR_WIDTH × QUEUE_WIDTH.
  - Lookup has absolute priority: cfg_tbl_ready = !s_hash_valid.
  - A table write occurs on an edge where cfg_tbl_valid and cfg_tbl_ready are both 1.
  - Contents are not cleared by reset; power-up content is 0.
- Lookup stage 1 (edge N, s_hash_valid=1): read table[s_hash[TABLE_ADDR_WIDTH-1:0]] into a register. Also register the hash, the type, and sel_default = !rss_enable | !s_hash_type[0].
- Lookup stage 2 (edge N+1): push {queue, hash, type} into the FIFO. queue = sel_default ? default_queue : table data. default_queue is sampled at edge N.
- FIFO: first-word-fall-through.
  - m_valid = !empty; the head is presented on m_*.
  - Pop on m_valid & m_ready.
  - Push while full with no pop in the same cycle: the entry is discarded and drop_count increments, saturating.
  - Push and pop in the same cycle while full: both succeed and the count is unchanged.
  - Push into an empty FIFO while m_ready=1: the entry still passes through the FIFO; m_valid rises the following cycle.
- Reset (asynchronous, any time) returns all outputs to their reset values below and clears in_frame. Any in-flight lookup is lost. The table is not cleared.

## Timing
- Reset values: hash_key=0, shadow key=0, cfg_key_pending=0, cfg_tbl_ready=1 (follows !s_hash_valid), m_valid=0, m_queue=0, m_hash=0, m_hash_type=0, drop_count=0.
- Lookup latency: a result presented in cycle N appears with m_valid=1 in cycle N+2 when the FIFO was empty.
- Throughput: one result per cycle is sustained when m_ready=1.
- A table write at edge N is visible to a lookup sampled at edge N+1.
- The key copy is visible on hash_key the cycle after the commit edge.
- m_* holds stable while m_valid=1 and m_ready=0.

## Test plan
- Table sequencing: write table[5]=0x03, then send s_hash=0x12345685, type=0x5, rss_enable=1 → m_queue=0x03, m_hash=0x12345685, m_valid rises 2 cycles after the strobe.
- Default selection: same table, send type=0x0 with default_queue=0x7 → m_queue=0x07. Then send rss_enable=0 with type=0x5 → m_queue=0x07.
- Write/lookup collision: cfg_tbl_valid and s_hash_valid asserted in the same cycle → cfg_tbl_ready=0 and the lookup returns the old entry. The write completes the next cycle and a later lookup returns the new value.
- Key commit deferral: write bytes 0..39 = 0x6D,0x5A,…, assert commit mid-frame → hash_key unchanged and cfg_key_pending=1 until the cycle after the tlast beat. Then hash_key[319:312]=0x6D and cfg_key_pending=0.
- Overflow: FIFO_DEPTH=4, hold m_ready=0, send 6 results → 4 buffered and drop_count=2. Then raise m_ready → 4 results drain in order.
- Asynchronous reset asserted with 2 entries queued and one lookup in flight → m_valid=0 immediately and drop_count=0. The table retains its contents.
